ks_pipelined_adder: RTL and testbench



---
 rtl/ks_adder_pkg.sv | 28 ++
 rtl/ks_prefix_level.sv | 22 ++
 rtl/ks_pipelined_adder.sv | 156 +++++++++++++++
 tb/tb_ks_pipelined_adder.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ks_adder_pkg.sv
// Shared types and helper functions for the Kogge-Stone pipelined adder.
package ks_adder_pkg;

    localparam int GP_MAX_W = 64;

    // Propagate/generate pair for datapaths up to GP_MAX_W bits wide.
    typedef struct packed {
        logic [GP_MAX_W-1:0] p;
        logic [GP_MAX_W-1:0] g;
    } gp_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    function automatic int popcount(input logic [31:0] v);
        int n;
        n = 0;
        for (int i = 0; i < 32; i++) n += int'(v[i]);
        return n;
    endfunction

endpackage

// File: rtl/ks_prefix_level.sv
// One combinational Kogge-Stone prefix level combining bit i with bit i-DIST.
module ks_prefix_level #(
    parameter int WIDTH = 19,
    parameter int DIST  = 1
) (
    input  logic [WIDTH-1:0] P_in,
    input  logic [WIDTH-1:0] G_in,
    output logic [WIDTH-1:0] P_out,
    output logic [WIDTH-1:0] G_out
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (i >= DIST) begin : g_op
            assign G_out[i] = G_in[i] | (G_in[i-DIST] & P_in[i]);
            assign P_out[i] = P_in[i] & P_in[i-DIST];
        end else begin : g_pass
            assign G_out[i] = G_in[i];
            assign P_out[i] = P_in[i];
        end
    end

endmodule

// File: rtl/ks_pipelined_adder.sv
// Parametrised Kogge-Stone adder with optional per-level registers and a global-stall handshake.
// Define KS_ADDER_SUB_EN to add the in_sub port (A - B with carry-out meaning no borrow).
module ks_pipelined_adder
    import ks_adder_pkg::*;
#(
    parameter int          WIDTH     = 19,
    parameter logic [31:0] PIPE_MASK = 32'b00100
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
`ifdef KS_ADDER_SUB_EN
    input  logic             in_sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout
);

    localparam int NLEV = clog2(WIDTH);

    logic             advance;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

    logic             in_vld_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic             cin_q;

    logic [WIDTH-1:0] fin_p, fin_g, fin_p0;
    logic             fin_cin, fin_vld;

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_d, sum_q;
    logic             cout_d, cout_q, out_vld_q;

    // Whole pipe moves together; a held output freezes every stage.
    assign advance  = ~out_vld_q | out_ready;
    assign in_ready = advance;

`ifdef KS_ADDER_SUB_EN
    assign b_eff   = in_sub ? ~in_b : in_b;
    assign cin_eff = in_sub ? 1'b1 : in_cin;
`else
    assign b_eff   = in_b;
    assign cin_eff = in_cin;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            in_vld_q <= 1'b0;
        end else if (advance) begin
            in_vld_q <= in_valid;
            a_q      <= in_a;
            b_q      <= b_eff;
            cin_q    <= cin_eff;
        end
    end

    for (genvar k = 0; k < NLEV; k++) begin : g_lvl
        logic [WIDTH-1:0] p_i, g_i, p0_i, p_c, g_c, p_o, g_o, p0_o;
        logic             cin_i, vld_i, cin_o, vld_o;

        if (k == 0) begin : g_first
            assign p_i   = a_q ^ b_q;
            assign g_i   = a_q & b_q;
            assign p0_i  = a_q ^ b_q;
            assign cin_i = cin_q;
            assign vld_i = in_vld_q;
        end else begin : g_next
            assign p_i   = g_lvl[k-1].p_o;
            assign g_i   = g_lvl[k-1].g_o;
            assign p0_i  = g_lvl[k-1].p0_o;
            assign cin_i = g_lvl[k-1].cin_o;
            assign vld_i = g_lvl[k-1].vld_o;
        end

        ks_prefix_level #(
            .WIDTH(WIDTH),
            .DIST (1 << k)
        ) u_lvl (
            .P_in (p_i),
            .G_in (g_i),
            .P_out(p_c),
            .G_out(g_c)
        );

        if (PIPE_MASK[k]) begin : g_reg
            logic [WIDTH-1:0] p_q, g_q, p0_q;
            logic             cin_q, vld_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_q <= 1'b0;
                end else if (advance) begin
                    vld_q <= vld_i;
                    p_q   <= p_c;
                    g_q   <= g_c;
                    p0_q  <= p0_i;
                    cin_q <= cin_i;
                end
            end
            assign p_o   = p_q;
            assign g_o   = g_q;
            assign p0_o  = p0_q;
            assign cin_o = cin_q;
            assign vld_o = vld_q;
        end else begin : g_comb
            assign p_o   = p_c;
            assign g_o   = g_c;
            assign p0_o  = p0_i;
            assign cin_o = cin_i;
            assign vld_o = vld_i;
        end
    end

    if (NLEV == 0) begin : g_tail_none
        assign fin_p   = a_q ^ b_q;
        assign fin_g   = a_q & b_q;
        assign fin_p0  = a_q ^ b_q;
        assign fin_cin = cin_q;
        assign fin_vld = in_vld_q;
    end else begin : g_tail
        assign fin_p   = g_lvl[NLEV-1].p_o;
        assign fin_g   = g_lvl[NLEV-1].g_o;
        assign fin_p0  = g_lvl[NLEV-1].p0_o;
        assign fin_cin = g_lvl[NLEV-1].cin_o;
        assign fin_vld = g_lvl[NLEV-1].vld_o;
    end

    // carry[i+1] is the carry out of bit i; the group P/G already spans bits [i:0].
    assign carry  = {fin_g | (fin_p & {WIDTH{fin_cin}}), fin_cin};
    assign sum_d  = fin_p0 ^ carry[WIDTH-1:0];
    assign cout_d = carry[WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld_q <= 1'b0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
        end else if (advance) begin
            out_vld_q <= fin_vld;
            sum_q     <= sum_d;
            cout_q    <= cout_d;
        end
    end

    assign out_valid = out_vld_q;
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;

endmodule

// File: tb/tb_ks_pipelined_adder.sv
// Self-checking bench for ks_pipelined_adder against an arithmetic reference model.
module tb_ks_pipelined_adder;
    import ks_adder_pkg::*;

    localparam int          W  = 19;
    localparam logic [31:0] PM = 32'b00100;
    localparam int          NL = clog2(W);
    localparam int          L  = 2 + popcount(PM & ((32'd1 << NL) - 32'd1));

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         in_cin = 1'b0;
    logic         in_sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_sum;
    logic         out_cout;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    ks_pipelined_adder #(
        .WIDTH    (W),
        .PIPE_MASK(PM)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_cin   (in_cin),
`ifdef KS_ADDER_SUB_EN
        .in_sub   (in_sub),
`endif
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_cout (out_cout)
    );

    // Reference: {cout, sum} of A+B+cin, or A + 2^W - B when subtracting.
    function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic cin, input logic sub);
        longint r;
        if (sub) r = longint'(a) + (longint'(1) << W) - longint'(b);
        else     r = longint'(a) + longint'(b) + longint'(cin);
        return r[W:0];
    endfunction

    task automatic send_one(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                            input logic sub, output logic [W-1:0] s, output logic co,
                            output int lat);
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_valid = 1'b1; in_a = a; in_b = b; in_cin = cin; in_sub = sub;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        s = out_sum; co = out_cout;
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++; $display("FAIL reset_out_valid got %b want 0", out_valid);
        end
        tests_run++;
        if (out_sum !== '0 || out_cout !== 1'b0) begin
            tests_failed++; $display("FAIL reset_out_data got %h/%b want 0/0", out_sum, out_cout);
        end
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++; $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
    endtask

    task automatic test_basic;
        logic [W-1:0] s; logic co; int lat;
        send_one(19'h12345, 19'h54321, 1'b0, 1'b0, s, co, lat);
        tests_run++;
        if (s !== 19'h66666 || co !== 1'b0) begin
            tests_failed++; $display("FAIL basic_sum got %h/%b want 66666/0", s, co);
        end
        tests_run++;
        if (lat != L) begin
            tests_failed++; $display("FAIL basic_latency got %0d want %0d", lat, L);
        end
    endtask

    task automatic test_wrap;
        logic [W-1:0] s; logic co; int lat;
        send_one(19'h7FFFF, 19'h00001, 1'b0, 1'b0, s, co, lat);
        tests_run++;
        if (s !== 19'h0 || co !== 1'b1 || lat != L) begin
            tests_failed++; $display("FAIL wrap_b1 got %h/%b lat %0d want 00000/1 lat %0d", s, co, lat, L);
        end
        send_one(19'h7FFFF, 19'h00000, 1'b1, 1'b0, s, co, lat);
        tests_run++;
        if (s !== 19'h0 || co !== 1'b1 || lat != L) begin
            tests_failed++; $display("FAIL wrap_cin got %h/%b lat %0d want 00000/1 lat %0d", s, co, lat, L);
        end
    endtask

    task automatic test_back_to_back;
        logic [W:0] q[$];
        logic [W:0] exp;
        int n_in, n_out, cyc;
        n_in = 0; n_out = 0; cyc = 0;
        in_sub = 1'b0;
        while (n_out < 100 && cyc < 1000) begin
            @(posedge clk); #1;
            out_ready = 1'b1;
            if (n_in < 100) begin
                in_valid = 1'b1;
                in_a = W'($urandom); in_b = W'($urandom); in_cin = 1'($urandom);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (out_valid && out_ready) begin
                tests_run++;
                if (q.size() == 0) begin
                    tests_failed++; $display("FAIL b2b_extra got %h/%b want none", out_sum, out_cout);
                end else begin
                    exp = q.pop_front();
                    if ({out_cout, out_sum} !== exp) begin
                        tests_failed++;
                        $display("FAIL b2b_result #%0d got %h/%b want %h/%b", n_out, out_sum, out_cout, exp[W-1:0], exp[W]);
                    end
                end
                n_out++;
            end
            if (in_valid && in_ready) begin
                q.push_back(ref_add(in_a, in_b, in_cin, in_sub));
                n_in++;
            end
            cyc++;
        end
        in_valid = 1'b0;
        tests_run++;
        if (n_out != 100 || cyc != 100 + L) begin
            tests_failed++; $display("FAIL b2b_throughput got %0d results in %0d cycles want 100 in %0d", n_out, cyc, 100 + L);
        end
    endtask

    task automatic test_stall;
        logic [W:0] q[$];
        logic [W:0] exp;
        logic [W-1:0] a, b, held_sum;
        logic c, have, held, held_cout;
        int n_in, n_out, cyc, total;
        n_in = 0; n_out = 0; cyc = 0; total = L + 10;
        have = 1'b0; held = 1'b0; a = '0; b = '0; c = 1'b0;
        held_sum = '0; held_cout = 1'b0;
        in_sub = 1'b0;
        while (n_out < total && cyc < 300) begin
            @(posedge clk); #1;
            if (cyc == L + 5) begin
                tests_run++;
                if (n_in != L) begin
                    tests_failed++; $display("FAIL stall_fill_count got %0d want %0d", n_in, L);
                end
            end
            out_ready = (cyc >= L + 5);
            if (!have && n_in < total) begin
                a = W'($urandom); b = W'($urandom); c = 1'($urandom);
                have = 1'b1;
            end
            in_valid = have; in_a = a; in_b = b; in_cin = c;
            @(negedge clk);
            if (!out_ready && out_valid) begin
                if (!held) begin
                    held_sum = out_sum; held_cout = out_cout; held = 1'b1;
                end else begin
                    tests_run++;
                    if (out_sum !== held_sum || out_cout !== held_cout) begin
                        tests_failed++; $display("FAIL stall_stable got %h/%b want %h/%b", out_sum, out_cout, held_sum, held_cout);
                    end
                end
                tests_run++;
                if (in_ready !== 1'b0) begin
                    tests_failed++; $display("FAIL stall_in_ready got %b want 0", in_ready);
                end
            end
            if (out_valid && out_ready) begin
                tests_run++;
                if (q.size() == 0) begin
                    tests_failed++; $display("FAIL stall_extra got %h/%b want none", out_sum, out_cout);
                end else begin
                    exp = q.pop_front();
                    if ({out_cout, out_sum} !== exp) begin
                        tests_failed++;
                        $display("FAIL stall_result #%0d got %h/%b want %h/%b", n_out, out_sum, out_cout, exp[W-1:0], exp[W]);
                    end
                end
                n_out++;
            end
            if (in_valid && in_ready) begin
                q.push_back(ref_add(in_a, in_b, in_cin, in_sub));
                n_in++;
                have = 1'b0;
            end
            cyc++;
        end
        in_valid = 1'b0;
        tests_run++;
        if (n_out != total || q.size() != 0) begin
            tests_failed++; $display("FAIL stall_drain got %0d results (%0d left) want %0d (0 left)", n_out, q.size(), total);
        end
    endtask

    task automatic test_reset_midflight;
        logic [W-1:0] s; logic [W:0] exp; logic co; int lat, bad;
        @(posedge clk); #1;
        out_ready = 1'b1; in_sub = 1'b0;
        in_valid = 1'b1; in_a = 19'h00011; in_b = 19'h00022; in_cin = 1'b0;
        @(posedge clk); #1;
        in_a = 19'h00033; in_b = 19'h00044;
        @(posedge clk); #1;
        in_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++; $display("FAIL midflight_out_valid got %b want 0", out_valid);
        end
        bad = 0;
        repeat (L + 3) begin
            @(posedge clk); #1;
            if (out_valid) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++; $display("FAIL midflight_emitted got %0d results want 0", bad);
        end
        exp = ref_add(19'h2AAAA, 19'h15555, 1'b1, 1'b0);
        send_one(19'h2AAAA, 19'h15555, 1'b1, 1'b0, s, co, lat);
        tests_run++;
        if ({co, s} !== exp || lat != L) begin
            tests_failed++; $display("FAIL midflight_next got %h/%b lat %0d want %h/%b lat %0d", s, co, lat, exp[W-1:0], exp[W], L);
        end
    endtask

`ifdef KS_ADDER_SUB_EN
    task automatic test_sub;
        logic [W-1:0] s, a, b; logic [W:0] exp; logic co; int lat;
        send_one(19'd5, 19'd7, 1'b0, 1'b1, s, co, lat);
        tests_run++;
        if (s !== 19'h7FFFE || co !== 1'b0) begin
            tests_failed++; $display("FAIL sub_borrow got %h/%b want 7fffe/0", s, co);
        end
        send_one(19'd7, 19'd5, 1'b1, 1'b1, s, co, lat);
        tests_run++;
        if (s !== 19'd2 || co !== 1'b1) begin
            tests_failed++; $display("FAIL sub_noborrow got %h/%b want 00002/1", s, co);
        end
        for (int i = 0; i < 10; i++) begin
            a = W'($urandom); b = W'($urandom);
            exp = ref_add(a, b, 1'b0, 1'b1);
            send_one(a, b, 1'($urandom), 1'b1, s, co, lat);
            tests_run++;
            if ({co, s} !== exp) begin
                tests_failed++; $display("FAIL sub_random got %h/%b want %h/%b", s, co, exp[W-1:0], exp[W]);
            end
        end
        in_sub = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_back_to_back();
        test_stall();
        test_reset_midflight();
`ifdef KS_ADDER_SUB_EN
        test_sub();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
